// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and helpers for the pipelined adder.
// add_ref is a plain behavioural model of the full-width operation.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int REF_W = 64;

    typedef struct packed {
        logic             ovf;
        logic             cout;
        logic [REF_W-1:0] sum;
    } ref_t;

    // Segment width; a zero stage count is guarded so the caller's
    // own parameter check can report it instead of a divide fault.
    function automatic int seg_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

    // Single wide-adder reference for widths 1..64.
    function automatic ref_t add_ref(
        input logic [REF_W-1:0] a,
        input logic [REF_W-1:0] b,
        input logic             cin,
        input logic             sub,
        input int               width
    );
        logic [REF_W:0]   full;
        logic [REF_W-1:0] mask;
        logic [REF_W-1:0] am;
        logic [REF_W-1:0] bm;
        logic [5:0]       msb;
        logic [6:0]       top;
        ref_t             r;
        if (width >= REF_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        msb    = 6'(width - 1);
        top    = 7'(width);
        am     = a & mask;
        bm     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bm} + 65'(cin ^ sub);
        r.sum  = full[REF_W-1:0] & mask;
        r.cout = full[top];
        r.ovf  = (am[msb] == bm[msb]) && (r.sum[msb] != am[msb]);
        return r;
    endfunction

endpackage

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: one combinational segment of the carry chain.
// Adds SEG bits of both operands plus the incoming carry.
module adder_pipe_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // Plain ripple of this segment; width is small by construction
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract split into carry-chained segments.
// Operands travel skewed, results de-skewed; valid/ready per stage.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    import adder_pkg::*;

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;
    localparam int SDIV = (STAGES < 1) ? 1 : STAGES;

    if ((STAGES < 1) || ((WIDTH % SDIV) != 0)) begin : g_bad_params
        $error("adder_pipe: STAGES must be >= 1 and divide WIDTH");
    end

    // Per-stage state
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic              ovf_q;

    // Per-stage inputs and combinational results
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_seg;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] mask;
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  r_in  [STAGES];
    logic [WIDTH-1:0]  r_nxt [STAGES];
    logic [SEG-1:0]    s_seg [STAGES];
    logic              ovf_nxt;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_pipe_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (a_in[k][k*SEG +: SEG]),
            .b    (b_in[k][k*SEG +: SEG]),
            .cin  (c_in[k]),
            .sum  (s_seg[k]),
            .cout (c_seg[k])
        );
    end

    // Stage inputs: stage 0 from the ports, later stages from the skew regs
    always_comb begin
        a_in[0] = a;
        b_in[0] = (sub == OP_SUB) ? ~b : b;
        c_in[0] = cin ^ (sub == OP_SUB);
        r_in[0] = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            r_in[k] = r_q[k-1];
            v_in[k] = v[k-1];
        end
    end

    // Splice each stage's segment result into the de-skewed result word
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_nxt[k] = r_in[k];
            r_nxt[k][k*SEG +: SEG] = s_seg[k];
        end
    end

    // Signed overflow is only known once the top segment has been added
    always_comb begin
        ovf_nxt = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
               && (r_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    end

    // A stage advances if it or any later stage is empty, or the sink takes
    // the head; computed in closed form to avoid a self-referencing chain
    always_comb begin
        mask = '0;
        adv  = '0;
        for (int k = 0; k < STAGES; k++) begin
            mask   = {STAGES{1'b1}} << k;
            adv[k] = out_ready || ((v & mask) != mask);
        end
    end

    // Valid bits and data registers; data only loads with a valid op so
    // a stalled or idle stage keeps its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k] <= a_in[k];
                        b_q[k] <= b_in[k];
                        r_q[k] <= r_nxt[k];
                        c_q[k] <= c_seg[k];
                    end
                end
            end
            if (adv[LAST] && v_in[LAST]) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign in_ready  = rst_n & adv[0];
    assign out_valid = v[LAST];
    assign sum       = r_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe at STAGES 4, 1 and 32.
// Directed cases, back-pressure, mid-stream reset and a random stream.
module tb_adder_pipe;
    import adder_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid_x;
    logic        out_ready;
    logic        out_ready_x;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        tp;

    logic        in_ready,  out_valid,  cout,  ovf;
    logic [31:0] sum;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [31:0] sum1;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] sum32;

    exp_t q[$];
    exp_t q1[$];
    exp_t q32[$];

    int checks;
    int fails;
    int cyc;
    int last_cyc;
    logic        tp_seen;
    logic        held;
    logic [33:0] h_val;

    assign in_valid_x = in_valid && tp;

    adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    adder_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_x), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready_x),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    adder_pipe #(.WIDTH(32), .STAGES(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_x), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid32), .out_ready(out_ready_x),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y,
                                input logic ci, input logic s);
        ref_t r;
        exp_t e;
        r      = add_ref({32'd0, x}, {32'd0, y}, ci, s, 32);
        e.sum  = r.sum[31:0];
        e.cout = r.cout;
        e.ovf  = r.ovf;
        return e;
    endfunction

    function automatic exp_t ex(input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    task automatic score(input string tag, ref exp_t qq[$],
                         input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        chk({tag, "_expected_pending"}, 64'(qq.size() != 0), 64'd1);
        if (qq.size() != 0) begin
            e = qq.pop_front();
            chk({tag, "_result"}, {30'd0, c, o, s}, {30'd0, e.cout, e.ovf, e.sum});
        end
    endtask

    // Presents one op (caller is just after a rising edge) and waits for
    // acceptance; the expected result is queued at the accepting cycle
    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s, input exp_t e);
        int n;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            q.push_back(e);
            if (tp) begin
                chk("x_ready", {62'd0, in_ready1, in_ready32}, 64'd3);
                q1.push_back(e);
                q32.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rsend();
        logic [31:0] x;
        logic [31:0] y;
        logic        ci;
        logic        s;
        x  = $urandom;
        y  = $urandom;
        ci = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        send(x, y, ci, s, mk(x, y, ci, s));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        cin      = 1'bx;
        sub      = 1'bx;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() + q1.size() + q32.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size() + q1.size() + q32.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge rst_n) begin
        q.delete();
        q1.delete();
        q32.delete();
    end

    // Output side: score results, hold stability under stall, stream gaps
    always @(negedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
        end else begin
            if (out_valid && out_ready) score("s4", q, sum, cout, ovf);
            if (out_valid1 && out_ready_x) score("s1", q1, sum1, cout1, ovf1);
            if (out_valid32 && out_ready_x) score("s32", q32, sum32, cout32, ovf32);
            if (held && out_valid && !out_ready) begin
                chk("hold_stable", {30'd0, cout, ovf, sum}, {30'd0, h_val});
            end
            held  <= out_valid && !out_ready;
            h_val <= {cout, ovf, sum};
            if (!tp) begin
                tp_seen <= 1'b0;
            end else if (out_valid && out_ready) begin
                if (tp_seen) chk("stream_gap", 64'(cyc - last_cyc), 64'd1);
                tp_seen  <= 1'b1;
                last_cyc <= cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        cyc         = 0;
        last_cyc    = 0;
        tp_seen     = 1'b0;
        held        = 1'b0;
        h_val       = '0;
        checks      = 0;
        fails       = 0;
        tp          = 1'b0;
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        out_ready_x = 1'b1;
        idle();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outputs", {30'd0, cout, ovf, sum}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Wrap-around and latency
        send(32'hFFFF_FFFF, 32'h1, 1'b0, OP_ADD, ex(32'h0, 1'b1, 1'b0));
        idle();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("latency", 64'(n), 64'd4);
        @(posedge clk);
        #1;
        drain();

        // Directed arithmetic, streamed back-to-back
        send(32'h7FFF_FFFF, 32'h1, 1'b0, OP_ADD, ex(32'h8000_0000, 1'b0, 1'b1));
        send(32'h8000_0000, 32'h1, 1'b0, OP_SUB, ex(32'h7FFF_FFFF, 1'b1, 1'b1));
        send(32'd5, 32'd7, 1'b0, OP_SUB, ex(32'hFFFF_FFFE, 1'b0, 1'b0));
        send(32'd5, 32'd3, 1'b1, OP_SUB, ex(32'h0000_0001, 1'b1, 1'b0));
        send(32'd1, 32'd2, 1'b1, OP_ADD, ex(32'h0000_0004, 1'b0, 1'b0));
        send(32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, ex(32'h0, 1'b1, 1'b1));
        idle();
        drain();

        // Back-pressure: sink stalls while ten ops stream in
        fork
            begin
                for (int i = 0; i < 10; i++) rsend();
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_in_flight", 64'(q.size()), 64'd4);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset pulse between edges with results in flight
        for (int i = 0; i < 5; i++) rsend();
        idle();
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_outputs", {30'd0, cout, ovf, sum}, 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD, ex(32'h2345_6789, 1'b0, 1'b0));
        send(32'h0000_0010, 32'h0000_0020, 1'b0, OP_SUB, ex(32'hFFFF_FFF0, 1'b0, 1'b0));
        idle();
        drain();

        // Random full-rate stream on all three configurations
        tp = 1'b1;
        for (int i = 0; i < 1000; i++) rsend();
        idle();
        drain();
        tp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
